// File: rtl/prf_seq_pkg.sv
// Shared types, register map and reset defaults for the PRF burst scheduler.
// Optional feature macro used by the top: PRF_SEQ_MISS_CNT_EN (missed-trigger counter).
package prf_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RF_DLY = 3'd1,
      ST_PH_ON  = 3'd2,
      ST_PH_OFF = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   localparam logic [1:0] TR_RISE   = 2'b01;
   localparam int         MAX_PHASE = 8;

   // Register map: 0 = rf_delay, 1+2k = width[k], 2+2k = period[k]
   localparam logic [3:0] ADDR_RF_DELAY = 4'd0;
   localparam logic [3:0] ADDR_WIDTH0   = 4'd1;
   localparam logic [3:0] ADDR_PERIOD0  = 4'd2;

   localparam logic [15:0] DEF_RF_DELAY = 16'd120;

   // Phases beyond the fourth repeat the four-entry default pattern.
   function automatic logic [15:0] def_width(input int k);
      case (k % 4)
         0:       return 16'd12;
         1:       return 16'd60;
         2:       return 16'd240;
         default: return 16'd600;
      endcase
   endfunction

   function automatic logic [15:0] def_period(input int k);
      case (k % 4)
         0:       return 16'd600;
         1:       return 16'd840;
         2:       return 16'd1560;
         default: return 16'd1200;
      endcase
   endfunction

   // Width and period addresses of phase k share the index (addr-1)>>1.
   function automatic logic [2:0] cfg_phase_idx(input logic [3:0] a);
      logic [3:0] m;
      m = a - 4'd1;
      return m[3:1];
   endfunction

endpackage

// File: rtl/prf_phase_timer.sv
// Shared cycle counter for the RF delay and every phase; saturates so the
// >= compares can never be skipped by a wrap.
module prf_phase_timer
   import prf_seq_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] width_i,
   input  logic [CNT_W-1:0] period_i,
   output logic             width_hit_o,
   output logic             period_hit_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // A load marks the first cycle of a new interval, so it counts as 1.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CNT_W'(1);
      end else if (clr_i) begin
         cnt_d = '0;
      end else if (cnt_q != '1) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign width_hit_o  = (cnt_q >= width_i);
   assign period_hit_o = (cnt_q >= period_i);

endmodule

// File: rtl/prf_seq_ctrl.sv
// Programmable PRF burst scheduler: RF delay then PHASE_NUM pulses from a shadowed table.
// Define PRF_SEQ_MISS_CNT_EN to add the saturating missed-trigger counter port miss_cnt.
module prf_seq_ctrl
   import prf_seq_pkg::*;
#(
   parameter int PHASE_NUM = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       tr_edge,
   input  logic             arm,
   input  logic             cfg_we,
   input  logic [3:0]       cfg_addr,
   input  logic [CNT_W-1:0] cfg_wdata,
   output logic             prf,
   output logic [1:0]       prf_edge,
   output logic             busy,
   output logic             done,
   output logic [2:0]       phase_idx,
   output logic [2:0]       dbg_state
`ifdef PRF_SEQ_MISS_CNT_EN
   ,
   output logic [15:0]      miss_cnt
`endif
);

   localparam logic [CNT_W:0] ONE_X = (CNT_W+1)'(1);

   state_e           state_q, state_d;
   logic [2:0]       phase_q, phase_d;
   logic             prf_q, busy_q, done_q;
   logic [1:0]       edge_q;

   logic [CNT_W-1:0] act_rf_q, sh_rf_q;
   logic [CNT_W-1:0] act_w_q [MAX_PHASE];
   logic [CNT_W-1:0] act_p_q [MAX_PHASE];
   logic [CNT_W-1:0] sh_w_q  [MAX_PHASE];
   logic [CNT_W-1:0] sh_p_q  [MAX_PHASE];

   logic             accept;
   logic [2:0]       wr_idx;
   logic             wr_ok;
   logic [2:0]       nxt_idx;
   logic [CNT_W-1:0] cur_w, cur_p, eff_p, tmr_w;
   logic [CNT_W:0]   w_p1;
   logic             tmr_clr, tmr_load, width_hit, period_hit;

   assign accept  = (state_q == ST_IDLE) && (tr_edge == TR_RISE) && arm;
   assign wr_idx  = cfg_phase_idx(cfg_addr);
   assign wr_ok   = (cfg_addr != ADDR_RF_DELAY) && (32'(wr_idx) < PHASE_NUM);
   assign nxt_idx = phase_q + 3'd1;

   // Active table: writable at any time, reloads defaults on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_rf_q <= CNT_W'(DEF_RF_DELAY);
         for (int k = 0; k < MAX_PHASE; k++) begin
            act_w_q[k] <= CNT_W'(def_width(k));
            act_p_q[k] <= CNT_W'(def_period(k));
         end
      end else if (cfg_we) begin
         if (cfg_addr == ADDR_RF_DELAY) begin
            act_rf_q <= cfg_wdata;
         end else if (wr_ok) begin
            if (cfg_addr[0]) begin
               act_w_q[wr_idx] <= cfg_wdata;
            end else begin
               act_p_q[wr_idx] <= cfg_wdata;
            end
         end
      end
   end

   // Shadow copy samples the pre-write active values on the accepting edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_rf_q <= '0;
         for (int k = 0; k < MAX_PHASE; k++) begin
            sh_w_q[k] <= '0;
            sh_p_q[k] <= '0;
         end
      end else if (accept) begin
         sh_rf_q <= act_rf_q;
         sh_w_q  <= act_w_q;
         sh_p_q  <= act_p_q;
      end
   end

   // Effective period = max(period, width+1), clamped to the counter range.
   always_comb begin
      cur_w = sh_w_q[phase_q];
      cur_p = sh_p_q[phase_q];
      w_p1  = {1'b0, cur_w} + ONE_X;
      if ({1'b0, cur_p} >= w_p1) begin
         eff_p = cur_p;
      end else if (w_p1[CNT_W]) begin
         eff_p = '1;
      end else begin
         eff_p = w_p1[CNT_W-1:0];
      end
      tmr_w = (state_q == ST_RF_DLY) ? sh_rf_q : cur_w;
   end

   prf_phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (tmr_clr),
      .load_i       (tmr_load),
      .width_i      (tmr_w),
      .period_i     (eff_p),
      .width_hit_o  (width_hit),
      .period_hit_o (period_hit)
   );

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      tmr_clr  = 1'b0;
      tmr_load = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tmr_clr = 1'b1;
            if (accept) begin
               tmr_load = 1'b1;
               // Zero RF delay goes straight to phase 0 so prf rises at E0+1.
               if (act_rf_q == '0) begin
                  phase_d = 3'd0;
                  state_d = (act_w_q[0] == '0) ? ST_PH_OFF : ST_PH_ON;
               end else begin
                  state_d = ST_RF_DLY;
               end
            end
         end
         ST_RF_DLY: begin
            if (width_hit) begin
               tmr_load = 1'b1;
               phase_d  = 3'd0;
               state_d  = (sh_w_q[0] == '0) ? ST_PH_OFF : ST_PH_ON;
            end
         end
         ST_PH_ON: begin
            if (width_hit) begin
               state_d = ST_PH_OFF;
            end
         end
         ST_PH_OFF: begin
            if (period_hit) begin
               if (phase_q == 3'(PHASE_NUM - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  tmr_load = 1'b1;
                  phase_d  = nxt_idx;
                  state_d  = (sh_w_q[nxt_idx] == '0) ? ST_PH_OFF : ST_PH_ON;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         phase_q <= 3'd0;
         prf_q   <= 1'b0;
         edge_q  <= 2'b11;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         prf_q   <= (state_d == ST_PH_ON);
         edge_q  <= {edge_q[0], prf_q};
         busy_q  <= (state_d != ST_IDLE);
         done_q  <= (state_d == ST_DONE);
      end
   end

`ifdef PRF_SEQ_MISS_CNT_EN
   logic [15:0] miss_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         miss_q <= 16'd0;
      end else if ((tr_edge == TR_RISE) && busy_q && (miss_q != 16'hFFFF)) begin
         miss_q <= miss_q + 16'd1;
      end
   end

   assign miss_cnt = miss_q;
`endif

   assign prf       = prf_q;
   assign prf_edge  = edge_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign phase_idx = phase_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_prf_seq_ctrl.sv
// Bench for prf_seq_ctrl: burst timeline model computed from the table, checked every cycle.
// Build with PRF_SEQ_MISS_CNT_EN defined to also check miss_cnt.
`timescale 1ns/1ps
module tb_prf_seq_ctrl;
   import prf_seq_pkg::*;

   localparam int PN = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  tr_edge = 2'b00;
   logic        arm = 1'b0;
   logic        cfg_we = 1'b0;
   logic [3:0]  cfg_addr = 4'd0;
   logic [15:0] cfg_wdata = 16'd0;
   logic        prf, busy, done;
   logic [1:0]  prf_edge;
   logic [2:0]  phase_idx, dbg_state;
`ifdef PRF_SEQ_MISS_CNT_EN
   logic [15:0] miss_cnt;
`endif

   always #5 clk = ~clk;

   prf_seq_ctrl #(
      .PHASE_NUM (PN),
      .CNT_W     (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tr_edge   (tr_edge),
      .arm       (arm),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .prf       (prf),
      .prf_edge  (prf_edge),
      .busy      (busy),
      .done      (done),
      .phase_idx (phase_idx),
      .dbg_state (dbg_state)
`ifdef PRF_SEQ_MISS_CNT_EN
      ,
      .miss_cnt  (miss_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;
   int t = 0;

   // Reference model: table plus the absolute timeline of the current burst.
   int         m_rf;
   int         m_w [PN];
   int         m_p [PN];
   bit         b_act;
   int         b_e0, b_done;
   int         b_st [PN];
   int         b_w  [PN];
   int         exp_miss;
   logic [1:0] exp_hist;
   logic       obs_prev;
   logic       arm_lvl;
   int         rise_q [$];
   int         done_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at cycle %0d: got %0h expected %0h", tag, t, obs, exp);
      end
   endtask

   function automatic logic m_busy(input int tt);
      return b_act && (tt >= b_e0 + 1) && (tt <= b_done);
   endfunction

   function automatic logic m_prf(input int tt);
      if (!b_act) return 1'b0;
      for (int k = 0; k < PN; k++)
         if (b_w[k] > 0 && tt >= b_st[k] && tt < b_st[k] + b_w[k]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int m_phase(input int tt);
      int r = 0;
      for (int k = 0; k < PN; k++)
         if (b_st[k] <= tt) r = k;
      return r;
   endfunction

   function automatic int get_rise(input int i);
      if (i < rise_q.size()) return rise_q[i];
      return -1;
   endfunction

   task automatic model_reset();
      m_rf     = 120;
      m_w      = '{12, 60, 240, 600};
      m_p      = '{600, 840, 1560, 1200};
      b_act    = 1'b0;
      exp_miss = 0;
      exp_hist = 2'b11;
      obs_prev = 1'b0;
   endtask

   task automatic model_write(input logic [3:0] a, input int d);
      int idx;
      if (a == 4'd0) begin
         m_rf = d;
      end else begin
         idx = (int'(a) - 1) / 2;
         if (idx < PN) begin
            if (int'(a) % 2 == 1) m_w[idx] = d;
            else m_p[idx] = d;
         end
      end
   endtask

   task automatic start_burst(input int e0);
      int s, eff;
      b_act = 1'b1;
      b_e0  = e0;
      s     = e0 + 1 + m_rf;
      for (int k = 0; k < PN; k++) begin
         b_st[k] = s;
         b_w[k]  = m_w[k];
         eff     = (m_p[k] > m_w[k]) ? m_p[k] : m_w[k] + 1;
         s       = s + eff;
      end
      b_done = s;
   endtask

   task automatic check_cycle();
      logic ep;
      ep = m_prf(t);
      chk("prf", prf, ep);
      chk("busy", busy, m_busy(t));
      chk("done", done, b_act && (t == b_done));
      chk("prf_edge", prf_edge, exp_hist);
      if (b_act && t >= b_st[0] && t <= b_done) chk("phase_idx", phase_idx, m_phase(t));
`ifdef PRF_SEQ_MISS_CNT_EN
      chk("miss_cnt", miss_cnt, exp_miss);
`endif
      if (prf === 1'b1 && obs_prev !== 1'b1) rise_q.push_back(t);
      if (done === 1'b1) done_seen = t;
      obs_prev = prf;
      exp_hist = {exp_hist[0], ep};
   endtask

   // One clock cycle: check outputs, then present this cycle's inputs.
   task automatic cycle(input logic [1:0] tr, input logic we, input logic [3:0] a, input int d);
      @(negedge clk);
      t++;
      check_cycle();
      tr_edge   = tr;
      arm       = arm_lvl;
      cfg_we    = we;
      cfg_addr  = a;
      cfg_wdata = 16'(d);
      if (tr == TR_RISE) begin
         if (m_busy(t)) begin
            if (exp_miss < 16'hFFFF) exp_miss++;
         end else if (arm_lvl) begin
            start_burst(t);
         end
      end
      if (we) model_write(a, d);
   endtask

   task automatic idle();
      logic [1:0] noise;
      case ($urandom_range(0, 2))
         0:       noise = 2'b00;
         1:       noise = 2'b10;
         default: noise = 2'b11;
      endcase
      cycle(noise, 1'b0, 4'd0, 0);
   endtask

   task automatic run_to_idle();
      while (t < b_done + 2) idle();
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst     = 1'b1;
      tr_edge = 2'b00;
      cfg_we  = 1'b0;
      #1;
      chk("rst_prf", prf, 1'b0);
      chk("rst_prf_edge", prf_edge, 2'b11);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_phase_idx", phase_idx, 3'd0);
`ifdef PRF_SEQ_MISS_CNT_EN
      chk("rst_miss_cnt", miss_cnt, 16'd0);
`endif
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      t++;
      exp_hist = {exp_hist[0], 1'b0};
   endtask

   int e0;
   int exp_r [4] = '{121, 721, 1561, 3121};
   int guard;

   initial begin
      arm_lvl = 1'b1;
      pulse_reset();
      repeat (3) idle();

      // Default burst; mid-burst rf_delay write and two ignored retriggers.
      rise_q.delete();
      done_seen = -1;
      cycle(TR_RISE, 1'b0, 4'd0, 0);
      e0 = t;
      while (t < b_done + 2) begin
         if (t + 1 == e0 + 50) cycle(2'b00, 1'b1, ADDR_RF_DELAY, 7);
         else if (t + 1 == e0 + 500 || t + 1 == e0 + 4321) cycle(TR_RISE, 1'b0, 4'd0, 0);
         else idle();
      end
      chk("def_rise_count", rise_q.size(), 4);
      for (int i = 0; i < 4; i++) chk("def_rise_time", get_rise(i), e0 + exp_r[i]);
      chk("def_done_time", done_seen, e0 + 4321);
`ifdef PRF_SEQ_MISS_CNT_EN
      chk("def_miss_two", miss_cnt, 16'd2);
`endif

      // rf_delay = 7 now applies.
      rise_q.delete();
      cycle(TR_RISE, 1'b0, 4'd0, 0);
      e0 = t;
      run_to_idle();
      chk("rf7_first_rise", get_rise(0), e0 + 8);

      // width[1] = 0: three pulses, phase 2 spacing preserved.
      cycle(2'b00, 1'b1, ADDR_RF_DELAY, 120);
      cycle(2'b00, 1'b1, 4'd3, 0);
      rise_q.delete();
      cycle(TR_RISE, 1'b0, 4'd0, 0);
      e0 = t;
      run_to_idle();
      chk("w0_rise_count", rise_q.size(), 3);
      chk("w0_phase2_rise", get_rise(1), e0 + 1561);

      // width[0] = 10, period[0] = 5: effective period 11.
      cycle(2'b00, 1'b1, 4'd3, 60);
      cycle(2'b00, 1'b1, ADDR_WIDTH0, 10);
      cycle(2'b00, 1'b1, ADDR_PERIOD0, 5);
      rise_q.delete();
      cycle(TR_RISE, 1'b0, 4'd0, 0);
      run_to_idle();
      chk("effp_spacing", get_rise(1) - get_rise(0), 11);

      // Disarmed trigger is ignored.
      arm_lvl = 1'b0;
      rise_q.delete();
      cycle(TR_RISE, 1'b0, 4'd0, 0);
      repeat (20) idle();
      chk("disarm_no_burst", rise_q.size(), 0);
      arm_lvl = 1'b1;

      // Reset during phase 2 high, then a full default burst.
      pulse_reset();
      cycle(TR_RISE, 1'b0, 4'd0, 0);
      e0 = t;
      while (t < e0 + 1661) idle();
      chk("pre_rst_prf_high", prf, 1'b1);
      pulse_reset();
      repeat (10) idle();
      rise_q.delete();
      done_seen = -1;
      cycle(TR_RISE, 1'b0, 4'd0, 0);
      e0 = t;
      run_to_idle();
      chk("post_rst_rise_count", rise_q.size(), 4);
      for (int i = 0; i < 4; i++) chk("post_rst_rise_time", get_rise(i), e0 + exp_r[i]);
      chk("post_rst_done_time", done_seen, e0 + 4321);

      // Randomized tables and mid-burst activity against the model.
      for (int it = 0; it < 10; it++) begin
         cycle(2'b00, 1'b1, ADDR_RF_DELAY, $urandom_range(0, 20));
         for (int k = 0; k < PN; k++) begin
            cycle(2'b00, 1'b1, 4'(1 + 2 * k), $urandom_range(0, 12));
            cycle(2'b00, 1'b1, 4'(2 + 2 * k), $urandom_range(0, 30));
         end
         cycle(2'b00, 1'b1, 4'($urandom_range(9, 15)), $urandom_range(0, 30));
         arm_lvl = 1'b1;
         if ($urandom_range(0, 1) == 1) cycle(TR_RISE, 1'b1, ADDR_RF_DELAY, $urandom_range(0, 20));
         else cycle(TR_RISE, 1'b0, 4'd0, 0);
         guard = 0;
         while (t < b_done + 3 && guard < 2000) begin
            guard++;
            case ($urandom_range(0, 19))
               0:       cycle(TR_RISE, 1'b0, 4'd0, 0);
               1:       cycle(2'b00, 1'b1, 4'($urandom_range(0, 15)), $urandom_range(0, 30));
               2:       begin arm_lvl = ~arm_lvl; idle(); end
               default: idle();
            endcase
         end
         arm_lvl = 1'b1;
         repeat (3) idle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
